// File: rtl/int2float_share_ctrl.sv
// int2float_share_ctrl
// Shares one external int -> float converter between NREQ requesters. A round-robin
// arbiter grants one request at a time. The operand is registered onto conv_in. The
// block waits CONV_LAT cycles, captures conv_out, and returns it with the requester
// id over a valid/ready response port.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester handshake; req_ready is one-hot and only set in IDLE
//   req_data          packed operands, requester i at [i*IN_W +: IN_W]
//   rsp_valid/ready   response handshake; rsp_data/rsp_id are held until accepted
//   conv_in/conv_out  registered operand to the shared converter and its result
//   busy              controller is not idle
module int2float_share_ctrl #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IN_W     = 11,
  parameter int unsigned OUT_W    = 7,
  parameter int unsigned CONV_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*IN_W-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [OUT_W-1:0]         rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  input  logic                     rsp_ready,
  output logic [IN_W-1:0]          conv_in,
  input  logic [OUT_W-1:0]         conv_out,
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = (CONV_LAT > 0) ? $clog2(CONV_LAT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

  state_e         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] grant_idx;
  logic           grant_vld;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [31:0] j;
    j         = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr) + k) % NREQ;
      if (!grant_vld && req_valid[j]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

  // Gated by rst_n so req_ready reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == StIdle) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      rr_ptr    <= '0;
      id        <= '0;
      cnt       <= '0;
      conv_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          // A grant in IDLE is always a handshake: ready is only raised on a valid bit.
          if (grant_vld) begin
            conv_in <= req_data[grant_idx*IN_W +: IN_W];
            id      <= grant_idx;
            cnt     <= CW'(CONV_LAT);
            rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            state   <= StConv;
          end
        end
        StConv: begin
          if (cnt == '0) begin
            rsp_data  <= conv_out;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= StResp;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_int2float_share_ctrl.sv
module tb_int2float_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, CONV_LAT = 1
  logic [3:0]  rv, rq;
  logic [43:0] rd;
  logic        sv, rr, by;
  logic [6:0]  sd, co;
  logic [1:0]  sid;
  logic [10:0] ci;

  // CONV_LAT = 0 instance
  logic [3:0]  z_rv, z_rq;
  logic [43:0] z_rd;
  logic        z_sv, z_rr, z_by;
  logic [6:0]  z_sd, z_co;
  logic [1:0]  z_sid;
  logic [10:0] z_ci;

  // CONV_LAT = 3 instance
  logic [3:0]  t_rv, t_rq;
  logic [43:0] t_rd;
  logic        t_sv, t_rr, t_by;
  logic [6:0]  t_sd, t_co;
  logic [1:0]  t_sid;
  logic [10:0] t_ci;
  logic [6:0]  t_p1, t_p2;

  int2float_share_ctrl #(.NREQ(4), .IN_W(11), .OUT_W(7), .CONV_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(rd), .req_ready(rq),
    .rsp_valid(sv), .rsp_data(sd), .rsp_id(sid), .rsp_ready(rr),
    .conv_in(ci), .conv_out(co), .busy(by)
  );

  int2float_share_ctrl #(.NREQ(4), .IN_W(11), .OUT_W(7), .CONV_LAT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(z_rv), .req_data(z_rd), .req_ready(z_rq),
    .rsp_valid(z_sv), .rsp_data(z_sd), .rsp_id(z_sid), .rsp_ready(z_rr),
    .conv_in(z_ci), .conv_out(z_co), .busy(z_by)
  );

  int2float_share_ctrl #(.NREQ(4), .IN_W(11), .OUT_W(7), .CONV_LAT(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(t_rv), .req_data(t_rd), .req_ready(t_rq),
    .rsp_valid(t_sv), .rsp_data(t_sd), .rsp_id(t_sid), .rsp_ready(t_rr),
    .conv_in(t_ci), .conv_out(t_co), .busy(t_by)
  );

  // Stub converters: low 7 bits xor 7'h55, delayed CONV_LAT cycles.
  always @(posedge clk) co <= ci[6:0] ^ 7'h55;
  assign z_co = z_ci[6:0] ^ 7'h55;
  always @(posedge clk) begin
    t_p1 <= t_ci[6:0] ^ 7'h55;
    t_p2 <= t_p1;
    t_co <= t_p2;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv = '0; rd = '0; rr = 1'b1;
    z_rv = '0; z_rd = '0; z_rr = 1'b1;
    t_rv = '0; t_rd = '0; t_rr = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rv = 4'b1111; rd = '0; rr = 1'b1;
    z_rv = '0; z_rd = '0; z_rr = 1'b1;
    t_rv = '0; t_rd = '0; t_rr = 1'b1;
    #1;
    checks++; if (rq !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", rq); end
    checks++; if (sv !== 1'b0 || by !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b%b want 00", sv, by); end
    checks++; if (sd !== 7'h00 || sid !== 2'd0 || ci !== 11'h000) begin errors++;
      $display("FAIL reset_regs got data=%h id=%0d conv_in=%h want 0 0 0", sd, sid, ci); end
    do_reset();
  endtask

  task automatic test_single();
    rv = 4'b0001; rd[0 +: 11] = 11'h00A; rr = 1'b1;
    #1;
    checks++; if (rq !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", rq); end
    tick(); // T+1
    rv = '0;
    checks++; if (by !== 1'b1 || ci !== 11'h00A || rq !== 4'b0000) begin errors++;
      $display("FAIL single_conv got busy=%b conv_in=%h rdy=%b want 1 00a 0000", by, ci, rq); end
    tick(); // T+2
    checks++; if (sv !== 1'b0) begin errors++; $display("FAIL single_early got rsp_valid=%b want 0", sv); end
    tick(); // T+3
    checks++; if (sv !== 1'b1 || sd !== 7'h5F || sid !== 2'd0) begin errors++;
      $display("FAIL single_rsp got v=%b d=%h id=%0d want 1 5f 0", sv, sd, sid); end
    tick(); // T+4
    checks++; if (sv !== 1'b0 || by !== 1'b0) begin errors++;
      $display("FAIL single_done got v=%b busy=%b want 0 0", sv, by); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [10:0] d;
    logic [6:0]  exp_d;
    int g;
    do_reset();
    rv = 4'b1111; rr = 1'b1;
    for (int i = 0; i < 4; i++) rd[i*11 +: 11] = 11'h7A0 + 11'(i * 3);
    for (int n = 0; n < 6; n++) begin
      g = n % 4;
      exp_rdy = 4'b0001 << g;
      d = 11'h7A0 + 11'(g * 3);
      exp_d = d[6:0] ^ 7'h55;
      #1;
      checks++; if (rq !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b want %b", n, rq, exp_rdy); end
      tick();
      if (n == 0) begin
        checks++; if (rq !== 4'b0000) begin errors++; $display("FAIL rr_noready got %b want 0000", rq); end
      end
      tick();
      tick();
      checks++; if (sv !== 1'b1 || sid !== 2'(g) || sd !== exp_d) begin errors++;
        $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h want 1 %0d %h", n, sv, sid, sd, g, exp_d); end
      tick();
    end
    rv = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rv = 4'b0100; rd[22 +: 11] = 11'h123; rr = 1'b0;
    #1;
    checks++; if (rq !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b want 0100", rq); end
    tick();
    rv = 4'b1011;
    tick();
    tick(); // T+3
    for (int k = 0; k < 5; k++) begin
      checks++; if (sv !== 1'b1 || sd !== 7'h76 || sid !== 2'd2 || rq !== 4'b0000 || ci !== 11'h123) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h id=%0d rdy=%b ci=%h want 1 76 2 0000 123",
                 k, sv, sd, sid, rq, ci);
      end
      tick();
    end
    rr = 1'b1;
    tick();
    #1;
    checks++; if (by !== 1'b0 || sv !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b v=%b want 0 0", by, sv); end
    checks++; if (rq !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got %b want 1000", rq); end
    rv = '0;
    tick();
    tick();
    tick();
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    z_rv = 4'b0010; z_rd[11 +: 11] = 11'h0C3; z_rr = 1'b1;
    t_rv = 4'b1000; t_rd[33 +: 11] = 11'h07F; t_rr = 1'b1;
    #1;
    checks++; if (z_rq !== 4'b0010 || t_rq !== 4'b1000) begin errors++;
      $display("FAIL lat_grant got %b %b want 0010 1000", z_rq, t_rq); end
    tick(); // T+1
    z_rv = '0; t_rv = '0;
    checks++; if (z_sv !== 1'b0) begin errors++; $display("FAIL lat0_early got %b want 0", z_sv); end
    tick(); // T+2
    checks++; if (z_sv !== 1'b1 || z_sd !== 7'h16 || z_sid !== 2'd1) begin errors++;
      $display("FAIL lat0_rsp got v=%b d=%h id=%0d want 1 16 1", z_sv, z_sd, z_sid); end
    checks++; if (t_sv !== 1'b0) begin errors++; $display("FAIL lat3_early2 got %b want 0", t_sv); end
    tick(); // T+3
    tick(); // T+4
    checks++; if (t_sv !== 1'b0) begin errors++; $display("FAIL lat3_early4 got %b want 0", t_sv); end
    tick(); // T+5
    checks++; if (t_sv !== 1'b1 || t_sd !== 7'h2A || t_sid !== 2'd3) begin errors++;
      $display("FAIL lat3_rsp got v=%b d=%h id=%0d want 1 2a 3", t_sv, t_sd, t_sid); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rv = 4'b0100; rd[22 +: 11] = 11'h155; rr = 1'b1;
    tick(); // CONV
    rv = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (by !== 1'b0 || sv !== 1'b0 || ci !== 11'h000 || sd !== 7'h00 || sid !== 2'd0 || rq !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async got busy=%b v=%b ci=%h d=%h id=%0d rdy=%b want all 0",
               by, sv, ci, sd, sid, rq);
    end
    rv = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (sv !== 1'b0 || by !== 1'b0) begin errors++;
        $display("FAIL midrst_quiet%0d got v=%b busy=%b want 0 0", k, sv, by); end
    end
    rv = 4'b1001;
    #1;
    checks++; if (rq !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got %b want 0001", rq); end
    tick();
    rv = '0;
    tick();
    tick();
    checks++; if (sv !== 1'b1 || sid !== 2'd0) begin errors++;
      $display("FAIL midrst_rsp got v=%b id=%0d want 1 0", sv, sid); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    rv = 4'b0010; rr = 1'b1;
    #1;
    checks++; if (rq !== 4'b0010) begin errors++; $display("FAIL wrap_setup got %b want 0010", rq); end
    tick();
    rv = '0;
    tick(); tick(); tick(); // idle, rr_ptr = 2
    rv = 4'b0011;
    #1;
    checks++; if (rq !== 4'b0001) begin errors++; $display("FAIL wrap_g0 got %b want 0001", rq); end
    tick(); tick(); tick(); tick();
    #1;
    checks++; if (rq !== 4'b0010) begin errors++; $display("FAIL wrap_g1 got %b want 0010", rq); end
    tick();
    rv = 4'b1011;
    tick(); tick(); tick();
    #1;
    checks++; if (rq !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got %b want 1000", rq); end
    tick(); tick(); tick(); tick();
    #1;
    checks++; if (rq !== 4'b0001) begin errors++; $display("FAIL wrap_g0_again got %b want 0001", rq); end
    rv = '0;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
